uart_rx_cfg: RTL and testbench

UART_RX_CFG -- requirements
Module: uart_rx_cfg

---
 rtl/uart_pkg.sv | 16 +
 rtl/uart_sync.sv | 21 ++
 rtl/uart_rx_cfg.sv | 169 ++++++++++++++++
 tb/tb_uart_rx_cfg.sv | 194 +++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// Shared types and constants for the configurable UART receiver.
package uart_pkg;

  typedef enum logic [2:0] {
    StIdle,
    StStart,
    StData,
    StParity,
    StStop
  } uart_state_e;

  localparam int unsigned PAR_NONE = 0;
  localparam int unsigned PAR_EVEN = 1;
  localparam int unsigned PAR_ODD  = 2;

endpackage

// File: rtl/uart_sync.sv
// Two-flop synchronizer for the asynchronous serial line; both flops reset to idle-high.
module uart_sync (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q
);

  logic meta_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      meta_q <= 1'b1;
      q      <= 1'b1;
    end else begin
      meta_q <= d;
      q      <= meta_q;
    end
  end

endmodule

// File: rtl/uart_rx_cfg.sv
// Configurable UART receiver with ready/valid output and frame/parity/overrun flags.
// Define UART_RX_PARITY_EN to compile in the parity bit and its check.
module uart_rx_cfg
  import uart_pkg::*;
#(
  parameter int unsigned CLK_HZ    = 50000000,
  parameter int unsigned BAUD      = 115200,
  parameter int unsigned DATA_BITS = 8,
  parameter int unsigned STOP_BITS = 1,
  parameter int unsigned PARITY    = 0
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 rx,
  output logic [DATA_BITS-1:0] data_out,
  output logic                 valid,
  input  logic                 ready,
  output logic                 frame_err,
  output logic                 parity_err,
  output logic                 overrun,
  output logic                 busy
);

  localparam int unsigned DIVISOR = CLK_HZ / BAUD;
  localparam int unsigned CntW    = $clog2(DIVISOR);

  localparam logic [CntW-1:0] CntFull = CntW'(DIVISOR - 1);
  localparam logic [CntW-1:0] CntHalf = CntW'((DIVISOR - 1) / 2);
  localparam logic [3:0]      DataLast = 4'(DATA_BITS - 1);
  localparam logic [3:0]      StopLast = 4'(STOP_BITS - 1);
  localparam bit              OddPar   = (PARITY == PAR_ODD);

`ifdef UART_RX_PARITY_EN
  localparam bit ParEn = (PARITY != PAR_NONE);
`else
  localparam bit ParEn = 1'b0;
`endif

  logic rx_s;

  uart_sync u_sync (
    .clk (clk),
    .rst (rst),
    .d   (rx),
    .q   (rx_s)
  );

  uart_state_e          state_q;
  logic [CntW-1:0]      cnt_q;
  logic [3:0]           bit_q;
  logic                 armed_q;
  logic [DATA_BITS-1:0] shift_q;
  logic                 ferr_acc_q;
  logic                 perr_acc_q;
  logic                 deliver_q;
  logic [DATA_BITS-1:0] data_q;
  logic                 valid_q;
  logic                 ferr_q;
  logic                 perr_q;
  logic                 overrun_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= StIdle;
      cnt_q      <= '0;
      bit_q      <= '0;
      armed_q    <= 1'b0;
      shift_q    <= '0;
      ferr_acc_q <= 1'b0;
      perr_acc_q <= 1'b0;
      deliver_q  <= 1'b0;
      data_q     <= '0;
      valid_q    <= 1'b0;
      ferr_q     <= 1'b0;
      perr_q     <= 1'b0;
      overrun_q  <= 1'b0;
    end else begin
      deliver_q <= 1'b0;
      overrun_q <= 1'b0;

      if (valid_q && ready) valid_q <= 1'b0;

      // A delivery either replaces an accepted/empty slot or is dropped as overrun.
      if (deliver_q) begin
        if (!valid_q || ready) begin
          data_q  <= shift_q;
          ferr_q  <= ferr_acc_q;
          perr_q  <= perr_acc_q;
          valid_q <= 1'b1;
        end else begin
          overrun_q <= 1'b1;
        end
      end

      unique case (state_q)
        StIdle: begin
          if (rx_s) begin
            armed_q <= 1'b1;
          end else if (armed_q) begin
            state_q    <= StStart;
            cnt_q      <= '0;
            bit_q      <= '0;
            ferr_acc_q <= 1'b0;
            perr_acc_q <= 1'b0;
          end
        end
        StStart: begin
          if (cnt_q == CntHalf) begin
            cnt_q   <= '0;
            state_q <= rx_s ? StIdle : StData;
          end else begin
            cnt_q <= cnt_q + CntW'(1);
          end
        end
        StData: begin
          if (cnt_q == CntFull) begin
            cnt_q   <= '0;
            shift_q <= {rx_s, shift_q[DATA_BITS-1:1]};
            if (bit_q == DataLast) begin
              bit_q   <= '0;
              state_q <= ParEn ? StParity : StStop;
            end else begin
              bit_q <= bit_q + 4'd1;
            end
          end else begin
            cnt_q <= cnt_q + CntW'(1);
          end
        end
        StParity: begin
          if (cnt_q == CntFull) begin
            cnt_q      <= '0;
            perr_acc_q <= rx_s ^ (^shift_q) ^ OddPar;
            state_q    <= StStop;
          end else begin
            cnt_q <= cnt_q + CntW'(1);
          end
        end
        StStop: begin
          if (cnt_q == CntFull) begin
            cnt_q <= '0;
            // A low stop bit means the line may still be low; wait for idle before re-arming.
            if (!rx_s) begin
              ferr_acc_q <= 1'b1;
              armed_q    <= 1'b0;
            end
            if (bit_q == StopLast) begin
              bit_q     <= '0;
              state_q   <= StIdle;
              deliver_q <= 1'b1;
            end else begin
              bit_q <= bit_q + 4'd1;
            end
          end else begin
            cnt_q <= cnt_q + CntW'(1);
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign data_out   = data_q;
  assign valid      = valid_q;
  assign frame_err  = ferr_q;
  assign parity_err = ParEn & perr_q;
  assign overrun    = overrun_q;
  assign busy       = (state_q != StIdle);

endmodule

// File: tb/tb_uart_rx_cfg.sv
// Directed bench for uart_rx_cfg at DIVISOR=10; define UART_RX_PARITY_EN to add even-parity cases.
module tb_uart_rx_cfg;

`ifdef UART_RX_PARITY_EN
  localparam int unsigned TbParity = 1;
`else
  localparam int unsigned TbParity = 0;
`endif

  logic       clk = 1'b0;
  logic       rst;
  logic       rx;
  logic       ready;
  logic [7:0] data_out;
  logic       valid;
  logic       frame_err;
  logic       parity_err;
  logic       overrun;
  logic       busy;

  int checks = 0;
  int errors = 0;

  // Monitor state, written only by the monitor process.
  int         valid_cycles = 0;
  int         ovr_pulses   = 0;
  int         busy_cycles  = 0;
  logic [7:0] cap_data     = 8'h00;
  logic       cap_fe       = 1'b0;
  logic       cap_pe       = 1'b0;

  uart_rx_cfg #(
    .CLK_HZ    (1000000),
    .BAUD      (100000),
    .DATA_BITS (8),
    .STOP_BITS (1),
    .PARITY    (TbParity)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .rx         (rx),
    .data_out   (data_out),
    .valid      (valid),
    .ready      (ready),
    .frame_err  (frame_err),
    .parity_err (parity_err),
    .overrun    (overrun),
    .busy       (busy)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (valid) begin
      valid_cycles++;
      cap_data = data_out;
      cap_fe   = frame_err;
      cap_pe   = parity_err;
    end
    if (overrun) ovr_pulses++;
    if (busy) busy_cycles++;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic send_bit(input logic b);
    rx = b;
    repeat (10) @(negedge clk);
  endtask

  task automatic send_frame(input logic [7:0] d, input logic par_bit, input logic stop);
    send_bit(1'b0);
    for (int i = 0; i < 8; i++) send_bit(d[i]);
`ifdef UART_RX_PARITY_EN
    send_bit(par_bit);
`else
    if (par_bit) rx = 1'b1;
`endif
    send_bit(stop);
  endtask

  task automatic idle(input int n);
    rx = 1'b1;
    repeat (n) @(negedge clk);
  endtask

  int v0;
  int o0;
  int b0;

  initial begin
    rst   = 1'b1;
    rx    = 1'b1;
    ready = 1'b1;
    repeat (3) @(negedge clk);
    check("reset_valid", {31'd0, valid}, 32'd0);
    check("reset_data", {24'd0, data_out}, 32'd0);
    check("reset_busy", {31'd0, busy}, 32'd0);
    check("reset_flags", {29'd0, frame_err, parity_err, overrun}, 32'd0);
    rst = 1'b0;
    idle(20);

    // Clean 0xA5, consumer always ready: exactly one valid cycle.
    v0 = valid_cycles;
    send_frame(8'hA5, ^8'hA5, 1'b1);
    idle(20);
    check("a5_valid_cycles", valid_cycles - v0, 32'd1);
    check("a5_data", {24'd0, cap_data}, 32'h0000_00A5);
    check("a5_flags", {30'd0, cap_fe, cap_pe}, 32'd0);
    check("a5_valid_low", {31'd0, valid}, 32'd0);

    // 3-clock glitch: START is entered briefly, then rejected without output.
    v0 = valid_cycles;
    b0 = busy_cycles;
    rx = 1'b0;
    repeat (3) @(negedge clk);
    idle(30);
    check("glitch_no_valid", valid_cycles - v0, 32'd0);
    check("glitch_was_busy", {31'd0, (busy_cycles > b0)}, 32'd1);
    check("glitch_idle", {31'd0, busy}, 32'd0);

    // 0x3C with low stop bit; line stays low so no new frame may start.
    v0 = valid_cycles;
    send_frame(8'h3C, ^8'h3C, 1'b0);
    send_bit(1'b0);
    send_bit(1'b0);
    check("fe_valid_cycles", valid_cycles - v0, 32'd1);
    check("fe_data", {24'd0, cap_data}, 32'h0000_003C);
    check("fe_flag", {31'd0, cap_fe}, 32'd1);
    check("fe_not_rearmed", {31'd0, busy}, 32'd0);
    idle(20);
    send_frame(8'h81, ^8'h81, 1'b1);
    idle(20);
    check("after_fe_data", {24'd0, cap_data}, 32'h0000_0081);
    check("after_fe_flag", {31'd0, cap_fe}, 32'd0);

    // Back-to-back 0x11, 0x22 while stalled: first word held, second dropped.
    ready = 1'b0;
    o0 = ovr_pulses;
    send_frame(8'h11, ^8'h11, 1'b1);
    send_frame(8'h22, ^8'h22, 1'b1);
    idle(20);
    check("ovr_valid_held", {31'd0, valid}, 32'd1);
    check("ovr_data_held", {24'd0, data_out}, 32'h0000_0011);
    check("ovr_pulses", ovr_pulses - o0, 32'd1);
    ready = 1'b1;
    @(negedge clk);
    check("ovr_valid_cleared", {31'd0, valid}, 32'd0);
    check("ovr_data_stable", {24'd0, data_out}, 32'h0000_0011);

    // Reset in the middle of 0xFF's data bits.
    rx = 1'b0;
    repeat (10) @(negedge clk);
    rx = 1'b1;
    repeat (35) @(negedge clk);
    check("mid_frame_busy", {31'd0, busy}, 32'd1);
    #2 rst = 1'b1;
    #1;
    check("rst_async_data", {24'd0, data_out}, 32'd0);
    check("rst_async_busy", {31'd0, busy}, 32'd0);
    check("rst_async_valid", {31'd0, valid}, 32'd0);
    @(negedge clk);
    rst = 1'b0;
    v0 = valid_cycles;
    idle(20);
    check("post_rst_no_valid", valid_cycles - v0, 32'd0);
    send_frame(8'h5A, ^8'h5A, 1'b1);
    idle(20);
    check("post_rst_count", valid_cycles - v0, 32'd1);
    check("post_rst_data", {24'd0, cap_data}, 32'h0000_005A);
    check("post_rst_fe", {31'd0, cap_fe}, 32'd0);

`ifdef UART_RX_PARITY_EN
    // Even parity: 0x07 has three ones, so a 0 parity bit is wrong and a 1 is right.
    send_frame(8'h07, 1'b0, 1'b1);
    idle(20);
    check("par_bad_data", {24'd0, cap_data}, 32'h0000_0007);
    check("par_bad_flag", {31'd0, cap_pe}, 32'd1);
    send_frame(8'h07, 1'b1, 1'b1);
    idle(20);
    check("par_good_flag", {31'd0, cap_pe}, 32'd0);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
